// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction fetch unit and its prefetch queue.
package ifu_prefetch_pkg;

  // inst[6:4] value shared by JAL/JALR/BRANCH opcodes
  localparam logic [2:0]  BJ_CLASS         = 3'b110;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic True_v    = 1'b1;
  localparam logic False_v   = 1'b0;
  localparam logic RstEnable = 1'b1;

  // Branch/jump class test on the low opcode bits of an instruction.
  function automatic logic is_bj(input logic [6:0] opc_low);
    return (opc_low[6:4] == BJ_CLASS);
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch queue: power-of-two FIFO with synchronous flush and occupancy count.
// Callers never push into a full queue or pop an empty one.
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and count next-state; flush overrides push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while non-empty
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential fetch with one outstanding request,
// prefetch queue, redirect flush with stale-response discard, and
// optional fetch hold after a branch/jump is enqueued.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter bit                BJ_HOLD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              bj_release,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_inst,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic              stall_req
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              outstanding_q, outstanding_d;
  logic              drop_q, drop_d;
  logic              hold_q, hold_d;

  logic              accept, resp, issue;
  logic              q_push, q_pop, q_flush, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head;

  assign accept = mem_req_q && !mem_busy;
  assign resp   = mem_valid && outstanding_q;

  // Reservation counts the in-flight slot so a response always has room.
  // Uses the registered count, so a dequeue from a full queue frees issue
  // only in the following cycle.
  assign issue = !mem_req_q && !outstanding_q && !hold_q && !redirect_valid &&
                 ((q_count + CNT_W'(outstanding_q)) < CNT_W'(QDEPTH));

  assign q_flush = rdy && redirect_valid;
  assign q_push  = rdy && resp && !drop_q && !redirect_valid;
  assign q_pop   = rdy && out_valid && out_ready && !redirect_valid;

  // Fetch control next-state; redirect dominates every other event
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    mem_addr_d    = mem_addr_q;
    mem_req_d     = mem_req_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    hold_d        = hold_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      hold_d     = False_v;
      mem_req_d  = False_v;
      if (accept) begin
        // memory took the old request at this very edge: its data is stale
        outstanding_d = True_v;
        drop_d        = True_v;
      end else if (outstanding_q) begin
        if (mem_valid) begin
          outstanding_d = False_v;
          drop_d        = False_v;
        end else begin
          drop_d = True_v;
        end
      end
    end else begin
      if (issue) begin
        mem_req_d  = True_v;
        mem_addr_d = fetch_pc_q;
      end
      if (accept) begin
        mem_req_d     = False_v;
        outstanding_d = True_v;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      end
      if (resp) begin
        outstanding_d = False_v;
        drop_d        = False_v;
      end
      if (bj_release) hold_d = False_v;
      if (BJ_HOLD && q_push && is_bj(mem_inst[6:0])) hold_d = True_v;
    end
  end

  // Fetch control registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      fetch_pc_q    <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_req_q     <= False_v;
      outstanding_q <= False_v;
      drop_q        <= False_v;
      hold_q        <= False_v;
    end else if (rdy) begin
      fetch_pc_q    <= fetch_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
    end
  end

  ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .data_i  ({mem_addr_q, mem_inst}),
    .data_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = !q_empty;
  // head fields read as zero while the queue is empty
  assign out_pc    = out_valid ? q_head[ENT_W-1 -: ADDR_W] : '0;
  assign out_inst  = out_valid ? q_head[INST_W-1:0] : '0;
  assign stall_req = out_ready && !out_valid;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: 1-cycle memory model, scoreboard of expected
// {pc, inst} entries, and directed scenarios for flow control, redirect,
// branch/jump hold and rdy freeze.
module tb_ifu_prefetch;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, redirect_valid, bj_release;
  logic [AW-1:0] redirect_pc;
  logic          mem_req, mem_busy, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_inst;
  logic          out_valid, out_ready, stall_req;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W   (AW),
    .INST_W   (IW),
    .QDEPTH   (QD),
    .RESET_PC (32'h0),
    .BJ_HOLD  (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bj_release     (bj_release),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_busy       (mem_busy),
    .mem_valid      (mem_valid),
    .mem_inst       (mem_inst),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready),
    .stall_req      (stall_req)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  int          n_deq    = 0;
  int          d0;
  logic [63:0] sb [$];
  logic [31:0] exp_req, exp_deliver, last_acc_addr, resp_addr;
  bit          mem_auto, bj_en, acc_seen;

  function automatic logic [31:0] mem_model(input logic [31:0] a, input bit bj);
    if (bj && a == 32'h4) return 32'h0000_006F;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: score pre-edge transfers, advance the model, drive memory.
  task automatic step();
    logic        acc;
    logic [31:0] acc_a;
    logic [63:0] e;
    bit          live;
    live     = rdy && !rst;
    acc      = live && mem_req && !mem_busy;
    acc_a    = mem_addr;
    acc_seen = acc;
    if (acc) begin
      check_eq("req_addr", mem_addr, exp_req);
      n_acc++;
      last_acc_addr = mem_addr;
    end
    if (live && redirect_valid) exp_req = redirect_pc;
    else if (acc) exp_req = exp_req + 32'd4;
    if (live && out_valid && out_ready && !redirect_valid) begin
      n_deq++;
      if (sb.size() == 0) check_eq("deq_unexpected", out_valid, 0);
      else begin
        e = sb.pop_front();
        check_eq("deq_pc", out_pc, e[63:32]);
        check_eq("deq_inst", out_inst, e[31:0]);
      end
    end
    if (live && mem_valid && !redirect_valid && resp_addr == exp_deliver) begin
      sb.push_back({resp_addr, mem_model(resp_addr, bj_en)});
      exp_deliver = exp_deliver + 32'd4;
    end
    if (live && redirect_valid) begin
      sb.delete();
      exp_deliver = redirect_pc;
    end
    if (rst) begin
      sb.delete();
      exp_req     = 32'h0;
      exp_deliver = 32'h0;
    end
    @(posedge clk);
    #1;
    if (rst) mem_valid = 1'b0;
    else if (rdy) begin
      mem_valid = acc && mem_auto;
      if (acc) begin
        resp_addr = acc_a;
        mem_inst  = mem_model(acc_a, bj_en);
      end
    end
    if (!rst) check_eq("out_valid", out_valid, (sb.size() != 0));
  endtask

  task automatic wait_acc(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = acc_seen;
    end
    check_eq(tag, got, 1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic manual_resp();
    mem_valid = 1'b1;
    mem_inst  = mem_model(resp_addr, bj_en);
    step();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    bj_release = 1'b0; mem_busy = 1'b0; mem_valid = 1'b0; mem_inst = '0;
    out_ready = 1'b1; mem_auto = 1'b1; bj_en = 1'b0;
    exp_req = '0; exp_deliver = '0; last_acc_addr = '0; resp_addr = '0;
    #1;
    step(); step();
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_inst", out_inst, 32'h0);
    check_eq("rst_stall", stall_req, 1);
    rst = 1'b0;

    // streaming with an always-ready decoder
    repeat (40) step();
    check_eq("t1_deq_cnt", (n_deq >= 8), 1);

    // backpressure fills the queue, one dequeue lets one fetch through
    out_ready = 1'b0;
    do_redirect(32'h0);
    n_acc = 0;
    repeat (30) step();
    check_eq("t2_acc_cnt", n_acc, 4);
    check_eq("t2_mem_req", mem_req, 0);
    check_eq("t2_stall", stall_req, 0);
    check_eq("t2_head", out_pc, 32'h0);
    n_acc = 0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("t2_no_same_cycle_issue", mem_req, 0);
    step();
    check_eq("t2_issue_next", mem_req, 1);
    repeat (8) step();
    check_eq("t2_refill_cnt", n_acc, 1);
    check_eq("t2_refill_addr", last_acc_addr, 32'h10);

    // redirect while a request is outstanding: its response is discarded
    out_ready = 1'b1;
    mem_auto  = 1'b0;
    do_redirect(32'h0);
    for (int k = 0; k < 2; k++) begin
      wait_acc("t3_acc");
      manual_resp();
    end
    wait_acc("t3_acc8");
    check_eq("t3_out_addr8", last_acc_addr, 32'h8);
    do_redirect(32'h100);
    check_eq("t3_withdrawn", mem_req, 0);
    manual_resp();
    check_eq("t3_no_stale", out_valid, 0);
    mem_auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    check_eq("t3_first_pc", out_pc, 32'h100);

    // redirect coinciding with a response and a dequeue
    out_ready = 1'b0;
    repeat (6) step();
    mem_auto = 1'b0;
    wait_acc("t4_acc");
    check_eq("t4_has_entry", out_valid, 1);
    mem_valid = 1'b1;
    mem_inst  = mem_model(resp_addr, bj_en);
    out_ready = 1'b1;
    do_redirect(32'h200);
    check_eq("t4_flushed", out_valid, 0);
    mem_auto = 1'b1;
    wait_acc("t4_acc2");
    check_eq("t4_next_addr", last_acc_addr, 32'h200);

    // branch/jump hold released by bj_release, then by redirect
    bj_en = 1'b1;
    do_redirect(32'h0);
    n_acc = 0;
    repeat (20) step();
    check_eq("t5_acc_cnt", n_acc, 2);
    check_eq("t5_mem_req", mem_req, 0);
    check_eq("t5_drained", out_valid, 0);
    bj_release = 1'b1;
    step();
    bj_release = 1'b0;
    wait_acc("t5_rel_acc");
    check_eq("t5_rel_addr", last_acc_addr, 32'h8);
    do_redirect(32'h0);
    n_acc = 0;
    repeat (20) step();
    check_eq("t5b_acc_cnt", n_acc, 2);
    do_redirect(32'h300);
    wait_acc("t5b_acc");
    check_eq("t5b_addr", last_acc_addr, 32'h300);
    bj_en = 1'b0;

    // rdy low freezes a pending, busy-blocked request and the queue
    out_ready = 1'b0;
    do_redirect(32'h400);
    repeat (7) step();
    mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) break;
      step();
    end
    check_eq("t6_req", mem_req, 1);
    check_eq("t6_addr", mem_addr, exp_req);
    rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_frz_req", mem_req, 1);
      check_eq("t6_frz_addr", mem_addr, exp_req);
      check_eq("t6_frz_head", out_pc, 32'h400);
    end
    rdy = 1'b1;
    mem_busy = 1'b0;
    d0 = n_deq;
    repeat (30) step();
    check_eq("t6_resume", ((n_deq - d0) >= 5), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit with a prefetch queue, for the RISC-V core front end. It generates sequential fetch addresses, issues one outstanding request at a time to the instruction memory port, and buffers returned {pc, inst} pairs in a QDEPTH-entry FIFO for the decoder. It supports redirect with flush and stale-response discard, plus an optional branch/jump fetch hold.

Parameters:
ADDR_W, 32, PC and memory address width
INST_W, 32, instruction width
QDEPTH, 4, queue entries; power of two, >=2
RESET_PC, 32'h0, first fetch address after reset
BJ_HOLD, 1, 1 = stop issuing fetches after enqueuing an inst with inst[6:4]==3'b110

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state is frozen
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
bj_release  in  1  lifts the branch/jump hold without a redirect
mem_req  out  1  fetch request valid
mem_addr  out  ADDR_W  fetch address
mem_busy  in  1  memory cannot accept; request accepted at an edge with mem_req=1, mem_busy=0
mem_valid  in  1  response strobe, one cycle
mem_inst  in  INST_W  response data, valid with mem_valid
out_valid  out  1  queue non-empty
out_pc  out  ADDR_W  head pc
out_inst  out  INST_W  head instruction
out_ready  in  1  decoder consumes head when out_valid && out_ready
stall_req  out  1  out_ready && !out_valid (combinational)

Behaviour:
- Reset:
  - fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, queue empty, out_valid=0, out_pc=0, out_inst=0.
  - outstanding=0, drop=0, hold=0.
- Clock gating: all updates occur only when rdy=1; with rdy=0, registers and outputs hold.
- Request issue:
  - Condition: mem_req=0 && outstanding=0 && !hold && (count+outstanding)<QDEPTH && !redirect_valid.
  - Effect: mem_req<=1, mem_addr<=fetch_pc.
  - mem_req and mem_addr stay stable until accepted.
  - On accept: mem_req<=0, outstanding<=1, fetch_pc<=fetch_pc+4 (mod 2^ADDR_W, wraps silently).
- Response (mem_valid with outstanding=1):
  - outstanding<=0.
  - If drop=0: enqueue {mem_addr, mem_inst}.
  - If drop=1: discard the data and clear drop.
  - mem_valid with outstanding=0 is ignored.
- Latency:
  - Response edge -> out_valid=1 at the next cycle.
  - Earliest next request: the cycle after the response edge.
- Capacity:
  - Reservation (count+outstanding) guarantees an enqueue never overflows.
  - Full queue with out_ready=0: no request is issued.
- Simultaneous dequeue and enqueue: both occur, count unchanged. When full, a dequeue in the same cycle does not enable issue until the next cycle.
- Redirect (takes priority over all other events in that cycle):
  - Queue flushed: count=0, any same-cycle enqueue and dequeue suppressed.
  - fetch_pc<=redirect_pc, hold<=0.
  - If mem_req=1 and not yet accepted: mem_req<=0, request withdrawn.
  - If outstanding=1 and no mem_valid that cycle: drop<=1.
  - If mem_valid arrives the same cycle: the response is discarded directly.
  - First new request: the cycle after the redirect, or after the stale response returns.
- BJ hold (BJ_HOLD=1):
  - Enqueuing an inst with [6:4]==3'b110 sets hold<=1.
  - hold blocks issue only; already-buffered entries still drain.
  - Cleared by redirect_valid or bj_release.
  - With BJ_HOLD=0, hold is never set.
- Reset mid-operation: all state returns to reset values; a pending memory response after reset is ignored (outstanding=0).

Decomposition:
- Shared defines: opcode-class constant 3'b110 (BJ class), RESET_PC default, True_v/False_v, RstEnable.
- Sub-module: ifu_fifo, parametrised (WIDTH=ADDR_W+INST_W, DEPTH=QDEPTH), synchronous flush input, count output.

Test Plan:
1. Reset, rdy=1, memory always ready with 1-cycle response, out_ready=1 -> requests at 0x0, 0x4, 0x8, ...; out_pc sequence 0x0, 0x4, 0x8, ...; out_inst matches memory.
2. out_ready=0, QDEPTH=4 -> exactly 4 requests accepted, count=4, mem_req stays 0. Raise out_ready for 1 cycle -> one dequeue, then one new request to 0x10.
3. Redirect to 0x100 while a request to 0x8 is outstanding -> 0x8 response discarded; next request addr 0x100; out_valid=0 until the 0x100 response; no 0x8 entry ever appears.
4. Redirect in the same cycle as mem_valid and an out_ready dequeue -> queue empty next cycle; fetch_pc=redirect_pc.
5. BJ_HOLD=1: memory returns 0x0000006F (jal) at pc 0x4 -> no request issued after 0x4 until bj_release; then the next request is to 0x8. With redirect instead of bj_release, the next request is to redirect_pc.
6. rdy=0 for 3 cycles mid-request with mem_busy=1 -> mem_req, mem_addr and queue unchanged. rdy=1 -> normal resume, no duplicated or lost entries.
